// File: rtl/sseg_scan_ctrl_if.sv
// Producer-side handshake for sseg_scan_ctrl: hex nibbles plus decimal points offered with valid/ready.
interface sseg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                value_valid;
    logic                value_ready;
    logic [DIGITS-1:0]   dp_in;

    modport master (output value, value_valid, dp_in, input value_ready);
    modport slave  (input value, value_valid, dp_in, output value_ready);
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed 7-segment scanner; registered outputs lag cnt/idx/shadow by one cycle.
// One pending frame buffer: value_ready drops after a transfer until it commits at frame end or while disabled.
module sseg_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD        = 500
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                blank_lz,
    sseg_scan_ctrl_if.slave     bus,
    output logic [6:0]          hex,
    output logic                dp_n,
    output logic [DIGITS-1:0]   an
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {OFF, SCAN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [IW-1:0]       idx_q;
    logic [4*DIGITS-1:0] pend_q, shadow_q;
    logic [DIGITS-1:0]   pend_dp_q, shadow_dp_q;
    logic                full_q, full_d, ready_q;
    logic                scan, wrap, commit, xfer;
    logic [3:0]          nib;
    logic                dp_sel, blank;
    logic [DIGITS-1:0]   an_d;
    logic [6:0]          hex_d;
    logic                dp_d;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF:     if (en)  state_d = SCAN;
            SCAN:    if (!en) state_d = OFF;
            default: state_d = OFF;
        endcase

        // Leaving SCAN takes effect in the same cycle en falls.
        scan   = (state_d == SCAN);
        wrap   = scan && (cnt_q == CW'(REFRESH_DIV - 1));
        commit = !en || (wrap && (idx_q == IW'(DIGITS - 1)));
        xfer   = bus.value_valid && ready_q;
        full_d = xfer ? 1'b1 : (commit ? 1'b0 : full_q);

        nib    = 4'h0;
        dp_sel = 1'b0;
        blank  = blank_lz && (idx_q != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx_q) begin
                nib    = shadow_q[4*i +: 4];
                dp_sel = shadow_dp_q[i];
            end
            if (IW'(i) >= idx_q && shadow_q[4*i +: 4] != 4'h0)
                blank = 1'b0;
        end

        an_d  = '1;
        hex_d = 7'h7F;
        dp_d  = 1'b1;
        if (scan && cnt_q >= CW'(DEAD)) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            hex_d = blank ? 7'h7F : glyph(nib);
            dp_d  = ~dp_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= OFF;
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            full_q      <= 1'b0;
            ready_q     <= 1'b0;
            an          <= '1;
            hex         <= 7'h7F;
            dp_n        <= 1'b1;
        end else begin
            state_q <= state_d;
            if (!scan) begin
                cnt_q <= '0;
                idx_q <= '0;
            end else if (wrap) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Commit copies the old pending contents even if a new transfer lands this cycle.
            if (commit) begin
                shadow_q    <= pend_q;
                shadow_dp_q <= pend_dp_q;
            end
            if (xfer) begin
                pend_q    <= bus.value;
                pend_dp_q <= bus.dp_in;
            end
            full_q  <= full_d;
            ready_q <= !full_d;
            an      <= an_d;
            hex     <= hex_d;
            dp_n    <= dp_d;
        end
    end

    assign bus.value_ready = ready_q;
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with DIGITS=4, REFRESH_DIV=8, DEAD=2 (32-cycle frames).
module tb_sseg_scan_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       blank_lz;
    logic [6:0] hex;
    logic       dp_n;
    logic [3:0] an;
    int         checks = 0;
    int         errors = 0;

    sseg_scan_ctrl_if #(.DIGITS(4)) bus ();

    sseg_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(8), .DEAD(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .blank_lz (blank_lz),
        .bus      (bus),
        .hex      (hex),
        .dp_n     (dp_n),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_cyc(input logic [3:0] a, input logic [6:0] h, input logic d,
                             input logic r, input string tag);
        @(negedge clk);
        chk({tag, ".an"}, 32'(an), 32'(a));
        chk({tag, ".hex"}, 32'(hex), 32'(h));
        chk({tag, ".dp_n"}, 32'(dp_n), 32'(d));
        chk({tag, ".rdy"}, 32'(bus.value_ready), 32'(r));
    endtask

    // One slot: two dark DEAD cycles, then six lit cycles of digit dig.
    task automatic check_slot(input int dig, input logic [6:0] h, input logic d,
                              input logic [7:0] rm, input string tag);
        logic [3:0] a;
        a = ~(4'b0001 << dig);
        for (int k = 0; k < 8; k++) begin
            if (k < 2) check_cyc(4'hF, 7'h7F, 1'b1, rm[k], $sformatf("%s.d%0d.k%0d", tag, dig, k));
            else       check_cyc(a, h, d, rm[k], $sformatf("%s.d%0d.k%0d", tag, dig, k));
        end
    endtask

    task automatic check_frame(input logic [27:0] hs, input logic [3:0] dps,
                               input logic [31:0] rm, input string tag);
        for (int i = 0; i < 4; i++)
            check_slot(i, hs[7*i +: 7], dps[i], rm[8*i +: 8], tag);
    endtask

    task automatic send(input logic [15:0] v, input logic [3:0] d);
        bus.value       = v;
        bus.dp_in       = d;
        bus.value_valid = 1'b1;
        @(posedge clk);
        #1 bus.value_valid = 1'b0;
    endtask

    int xfers;
    int bad;

    initial begin
        reset = 1'b1; en = 1'b0; blank_lz = 1'b0;
        bus.value = '0; bus.dp_in = '0; bus.value_valid = 1'b0;
        repeat (2) check_cyc(4'hF, 7'h7F, 1'b1, 1'b0, "rst");
        reset = 1'b0;
        check_cyc(4'hF, 7'h7F, 1'b1, 1'b1, "post_rst");

        // Zero shadow, no blanking: every digit shows '0'.
        en = 1'b1;
        check_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 32'hFFFF_FFFF, "f1");

        // Mid-frame load stays invisible until the frame ends.
        check_slot(0, 7'h40, 1'b1, 8'hFF, "f2");
        check_slot(1, 7'h40, 1'b1, 8'hFF, "f2");
        send(16'h12AF, 4'b0100);
        check_slot(2, 7'h40, 1'b1, 8'h00, "f2");
        check_slot(3, 7'h40, 1'b1, 8'h80, "f2");

        blank_lz = 1'b1;
        send(16'h0005, 4'b0000);
        check_frame({7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011, 32'h8000_0000, "f3");
        send(16'h0000, 4'b0000);
        check_frame({7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'hF, 32'h8000_0000, "f4");
        send(16'h0105, 4'b0000);
        check_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 32'h8000_0000, "f5");
        check_frame({7'h7F, 7'h79, 7'h40, 7'h12}, 4'hF, 32'hFFFF_FFFF, "f6");

        // Disable mid-slot with a value pending.
        send(16'h9876, 4'b1001);
        check_slot(0, 7'h12, 1'b1, 8'h00, "f7");
        check_cyc(4'hF, 7'h7F, 1'b1, 1'b0, "f7.d1.k0");
        check_cyc(4'hF, 7'h7F, 1'b1, 1'b0, "f7.d1.k1");
        check_cyc(4'b1101, 7'h40, 1'b1, 1'b0, "f7.d1.k2");
        check_cyc(4'b1101, 7'h40, 1'b1, 1'b0, "f7.d1.k3");
        en = 1'b0;
        repeat (3) check_cyc(4'hF, 7'h7F, 1'b1, 1'b1, "off");
        en = 1'b1;
        check_frame({7'h10, 7'h00, 7'h78, 7'h02}, 4'b0110, 32'hFFFF_FFFF, "f8");

        // Continuous offers: one transfer per frame, never a glyph in DEAD cycles.
        xfers = 0;
        bad   = 0;
        bus.value       = 16'h1234;
        bus.dp_in       = 4'b0011;
        bus.value_valid = 1'b1;
        for (int c = 0; c < 96; c++) begin
            if (bus.value_ready) xfers++;
            @(posedge clk);
            #1 bus.value = bus.value + 16'h1357;
            @(negedge clk);
            if ($countones(~an) > 1) bad++;
            if ((c % 8) < 2 && (an != 4'hF || hex != 7'h7F || dp_n != 1'b1)) bad++;
        end
        chk("stream.xfers", 32'(xfers), 32'd3);
        chk("stream.bad", 32'(bad), 32'd0);

        // Leave a value pending, then reset: it must never reach the display.
        @(posedge clk);
        #1 bus.value_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("pend.rdy", 32'(bus.value_ready), 32'd0);
        end
        reset = 1'b1;
        repeat (2) check_cyc(4'hF, 7'h7F, 1'b1, 1'b0, "rst2");
        reset = 1'b0;
        check_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 32'hFFFF_FFFF, "r1");
        check_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 32'hFFFF_FFFF, "r2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits, 1 to 8.
REQ-002 Parameter REFRESH_DIV, default 50000: clk cycles per digit slot, at least DEAD+2.
REQ-003 Parameter DEAD, default 500: blanking cycles at the start of each slot (anti-ghosting), at least 1.
REQ-004 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port en, input, 1: scan enable; 0 turns the display dark.
REQ-007 Port value, input, 4*DIGITS: hex nibbles; digit i = value[4i+3:4i]; digit 0 is rightmost.
REQ-008 Port value_valid, input, 1: producer offers value and dp_in.
REQ-009 Port value_ready, output, 1: controller can accept a new value.
REQ-010 Port dp_in, input, DIGITS: decimal-point request per digit, active-high.
REQ-011 Port blank_lz, input, 1: leading-zero blanking enable, sampled every cycle.
REQ-012 Port hex, output, 7: segments, active-low; produced by the existing sseg hex decoder glyph set.
REQ-013 Port dp_n, output, 1: decimal point, active-low.
REQ-014 Port an, output, DIGITS: digit selects, active-low, at most one low.

Function
REQ-015 A transfer occurs on any cycle with value_valid=1 and value_ready=1; value and dp_in are captured into a pending register.
REQ-016 After a transfer, value_ready shall be 0 from the next cycle until the pending register is committed.
REQ-017 Commit: on the cycle the slot counter wraps while idx=DIGITS-1, or on any cycle with en=0, pending shall be copied to the display shadow. value_ready shall return to 1 on the following cycle. This gives tear-free frames.
REQ-018 States: OFF (en=0) and SCAN (en=1). OFF to SCAN when en=1. SCAN to OFF when en=0, effective the same cycle.
REQ-019 On entry to SCAN, cnt=0 and idx=0.
REQ-020 In SCAN, cnt counts 0 to REFRESH_DIV-1 and then wraps to 0. On the wrap, idx advances modulo DIGITS (DIGITS-1 wraps to 0).
REQ-021 Outputs are registered. For cnt<DEAD the outputs are: an all 1, hex=7'h7F, dp_n=1.
REQ-022 For cnt>=DEAD, an[idx]=0 and all other an bits are 1.
REQ-023 For cnt>=DEAD, hex shall be the glyph of shadow nibble idx, unless that digit is blanked.
REQ-024 For cnt>=DEAD, dp_n = NOT shadow_dp[idx]; the decimal point is never blanked.
REQ-025 Blanking: digit idx>0 is blanked (hex=7'h7F) when blank_lz=1 and all shadow nibbles idx..DIGITS-1 are 0. Digit 0 is never blanked.
REQ-026 In OFF: an all 1, hex=7'h7F, dp_n=1, counters held at 0; value_ready follows REQ-016/017.
REQ-027 A simultaneous transfer and commit on the same cycle: the old pending value commits, the new value becomes pending, and value_ready=0 on the next cycle.
REQ-028 Output latency: registered outputs reflect cnt/idx/shadow with exactly one cycle of delay.

Reset
REQ-029 While reset=1 (dominant over en/valid): an all 1, hex=7'h7F, dp_n=1, value_ready=0; cnt, idx, shadow, pending and pending_dp cleared; state OFF.
REQ-030 The cycle after reset deasserts, value_ready=1.
REQ-031 Reset asserted mid-slot or with a pending value discards the pending value; no commit occurs.

Verification (bench: DIGITS=4, REFRESH_DIV=8, DEAD=2)
REQ-032 Reset then en=1 with shadow 0 and blank_lz=0 -> slot 0: an=4'hF for 2 cycles, then an=4'b1110 with hex=7'b1000000 for 6 cycles; then digit 1 the same way; the frame repeats every 32 cycles.
REQ-033 Load value=16'h12AF, dp_in=4'b0100 mid-frame -> value_ready=0 until the idx=3 wrap. Next frame shows, for digits 0..3: 7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001. dp_n=0 only in the digit 2 slot.
REQ-034 value=16'h0005, blank_lz=1 -> digits 1-3 show hex=7'h7F with their an bit low; digit 0 shows 7'b0010010. With value=16'h0000, digit 0 shows 7'b1000000.
REQ-035 Drop en to 0 mid-slot -> next cycle an=4'hF; a pending value commits and value_ready=1 the cycle after. Restoring en restarts at idx=0, cnt=0.
REQ-036 Hold value_valid=1 continuously with a changing value -> exactly one transfer per frame; an never has two bits low; no glyph is shown during the DEAD cycles.
